// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Contents:
//   - Operation encodings OP_MULTU/OP_MULT/OP_DIVU/OP_DIV. The control unit
//     drives the same values on the op bus.
//   - Unit FSM state encodings S_IDLE/S_CALC/S_FIX.
//   - Default datapath width.
package mult_div_unit_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit feeding the architectural HI/LO pair.
// Multiply is shift-add and divide is restoring shift-subtract. Both work on
// operand magnitudes, and the sign is fixed up in a final cycle.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   start, op        operation request (sampled in IDLE only) and its opcode
//   opA, opB         multiplicand/dividend and multiplier/divisor
//   writeHi/writeLo  direct HI/LO writes from writeData (honoured in IDLE only)
//   hi, lo           architectural HI/LO registers
//   busy             operation in progress
//   done             one-cycle pulse when an operation updates hi/lo
//   divZero          set with done; 1 when a divide had a zero divisor
//   stateDbg         current FSM state, for observation
//
// Handshake: start is a one-cycle request. It is accepted only on an edge
// where busy is low. A request made while busy is high is dropped; there is
// no queueing. done is the one-cycle completion response. It comes exactly
// 33 edges after the accepting edge, and hi/lo/divZero are valid from that
// point until the next completion or direct write.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             writeHi,
    input  logic             writeLo,
    input  logic [WIDTH-1:0] writeData,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             divZero,
    output logic [1:0]       stateDbg
);

    function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    state_t                 state, stateNext;
    op_t                    opReg;
    logic [CNT_W-1:0]       count;
    logic [2*WIDTH-1:0]     acc;
    logic [WIDTH-1:0]       magA, magB;
    logic                   resNeg, remNeg;
    logic [WIDTH-1:0]       hiReg, loReg;
    logic                   doneReg, divZeroReg;

    // Operand preparation at the accepting edge
    logic                   signedIn, aNegIn, bNegIn;
    logic [WIDTH-1:0]       magAIn, magBIn;

    // One iteration step of each algorithm
    logic [WIDTH:0]         mulSum;
    logic [2*WIDTH-1:0]     mulNext;
    logic [WIDTH:0]         divShift, divDiff;
    logic                   divGe;
    logic [2*WIDTH-1:0]     divNext;

    // Sign-corrected results
    logic [2*WIDTH-1:0]     prodFix;
    logic [WIDTH-1:0]       quotFix, remFix;
    logic [WIDTH-1:0]       hiResult, loResult;
    logic                   divZeroResult;

    always_comb begin
        signedIn = (op == OP_MULT) || (op == OP_DIV);
        aNegIn   = signedIn && opA[WIDTH-1];
        bNegIn   = signedIn && opB[WIDTH-1];
        magAIn   = signedIn ? absVal(opA) : opA;
        magBIn   = signedIn ? absVal(opB) : opB;
    end

    // Multiply: the upper half accumulates the partial product. The lower
    // half starts as the multiplier and is shifted out one bit per step, so
    // after WIDTH steps acc holds the full product.
    always_comb begin
        mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, magA} : '0);
        mulNext = {mulSum, acc[WIDTH-1:1]};
    end

    // Divide: the upper half is the partial remainder. The lower half starts
    // as the dividend, and quotient bits are shifted in from the bottom. The
    // remainder stays below the divisor, so the shifted value fits in
    // WIDTH+1 bits. A zero divisor walks through harmlessly, and its result
    // is overridden in FIX.
    always_comb begin
        divShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        divGe    = divShift >= {1'b0, magB};
        divDiff  = divShift - {1'b0, magB};
        divNext  = {(divGe ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0]),
                    acc[WIDTH-2:0], divGe};
    end

    always_comb begin
        prodFix       = resNeg ? -acc : acc;
        quotFix       = resNeg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        remFix        = remNeg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        divZeroResult = opReg[1] && (magB == '0);
        if (!opReg[1]) begin
            hiResult = prodFix[2*WIDTH-1:WIDTH];
            loResult = prodFix[WIDTH-1:0];
        end else if (divZeroResult) begin
            // Zero divisor: all-ones quotient, and HI returns the original dividend
            hiResult = remNeg ? -magA : magA;
            loResult = '1;
        end else begin
            hiResult = remFix;
            loResult = quotFix;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            S_IDLE:  if (start) stateNext = S_CALC;
            S_CALC:  if (count == '1) stateNext = S_FIX;
            S_FIX:   stateNext = S_IDLE;
            default: stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opReg      <= OP_MULTU;
            count      <= '0;
            acc        <= '0;
            magA       <= '0;
            magB       <= '0;
            resNeg     <= 1'b0;
            remNeg     <= 1'b0;
            hiReg      <= '0;
            loReg      <= '0;
            doneReg    <= 1'b0;
            divZeroReg <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (writeHi) hiReg <= writeData;
                    if (writeLo) loReg <= writeData;
                    if (start) begin
                        opReg  <= op_t'(op);
                        magA   <= magAIn;
                        magB   <= magBIn;
                        resNeg <= aNegIn ^ bNegIn;
                        remNeg <= aNegIn;
                        count  <= '0;
                        acc    <= op[1] ? {{WIDTH{1'b0}}, magAIn}
                                        : {{WIDTH{1'b0}}, magBIn};
                    end
                end
                S_CALC: begin
                    count <= count + CNT_W'(1);
                    acc   <= opReg[1] ? divNext : mulNext;
                end
                S_FIX: begin
                    hiReg      <= hiResult;
                    loReg      <= loResult;
                    doneReg    <= 1'b1;
                    divZeroReg <= divZeroResult;
                end
                default: ;
            endcase
        end
    end

    assign hi       = hiReg;
    assign lo       = loReg;
    assign busy     = (state != S_IDLE);
    assign done     = doneReg;
    assign divZero  = divZeroReg;
    assign stateDbg = state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit. It drives inputs on the falling edge and
// samples outputs on the falling edge. Expected values are hand-computed.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] opA = '0, opB = '0, writeData = '0;
    logic        writeHi = 1'b0, writeLo = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, done, divZero;
    logic [1:0]  stateDbg;

    int nAsserts = 0;
    int nFail    = 0;

    // Clock and reset
    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .opA(opA), .opB(opB),
        .writeHi(writeHi), .writeLo(writeLo), .writeData(writeData),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .divZero(divZero),
        .stateDbg(stateDbg)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic pulseStart(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; opA = a; opB = b;
        @(negedge clk);
        // Operands only need to be held at the accepting edge
        start = 1'b0;
        op  = 2'($urandom_range(0, 3));
        opA = $urandom;
        opB = $urandom;
    endtask

    task automatic waitDone(output int lat, output int busyCycles);
        lat = 0;
        busyCycles = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
            if (busy === 1'b1) busyCycles++;
        end
    endtask

    task automatic runOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input string tag, input logic [31:0] expHi, input logic [31:0] expLo,
                         input logic expDz);
        int lat, busyCycles;
        pulseStart(o, a, b);
        waitDone(lat, busyCycles);
        check({tag, "_latency"}, 64'(lat), 64'd33);
        check({tag, "_busy_cycles"}, 64'(busyCycles), 64'd33);
        check({tag, "_hi"}, 64'(hi), 64'(expHi));
        check({tag, "_lo"}, 64'(lo), 64'(expLo));
        check({tag, "_divZero"}, 64'(divZero), 64'(expDz));
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    endtask

    initial begin
        int lat, busyCycles, doneCount;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_divZero", 64'(divZero), 64'd0);
        check("reset_state", 64'(stateDbg), 64'(S_IDLE));
        rst = 1'b0;

        // Unsigned multiply at the extremes
        runOp(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

        // Direct writes in IDLE
        @(negedge clk); writeLo = 1'b1; writeData = 32'h0000_1234;
        @(negedge clk); writeLo = 1'b0;
        check("mtlo_lo", 64'(lo), 64'h1234);
        check("mtlo_hi_kept", 64'(hi), 64'hFFFF_FFFE);
        @(negedge clk); writeHi = 1'b1; writeLo = 1'b1; writeData = 32'hABCD_1234;
        @(negedge clk); writeHi = 1'b0; writeLo = 1'b0;
        check("mthi_mtlo_hi", 64'(hi), 64'hABCD_1234);
        check("mthi_mtlo_lo", 64'(lo), 64'hABCD_1234);

        // Signed and unsigned arithmetic
        runOp(OP_MULT, 32'hFFFF_FFFD, 32'd7, "mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        runOp(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        runOp(OP_DIVU, 32'd100, 32'd7, "divu", 32'd2, 32'd14, 1'b0);
        runOp(OP_DIVU, 32'd100, 32'd0, "divu_zero", 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
        runOp(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_wrap", 32'h0, 32'h8000_0000, 1'b0);

        // A start and a write while busy are both ignored
        pulseStart(OP_MULTU, 32'd6, 32'd7);
        repeat (4) @(negedge clk);
        start = 1'b1; op = OP_DIVU; opA = 32'd100; opB = 32'd7;
        writeLo = 1'b1; writeData = 32'h0000_1234;
        @(negedge clk);
        start = 1'b0; writeLo = 1'b0;
        check("busy_write_lo_ignored", 64'(lo), 64'h8000_0000);
        check("busy_still_high", 64'(busy), 64'd1);
        doneCount = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done === 1'b1) doneCount++;
        end
        check("busy_start_single_done", 64'(doneCount), 64'd1);
        check("busy_start_hi", 64'(hi), 64'd0);
        check("busy_start_lo", 64'(lo), 64'd42);

        // A write and a start on the same IDLE edge: the write lands, and the result overwrites it later
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; opA = 32'd5; opB = 32'd5;
        writeHi = 1'b1; writeData = 32'h0000_DEAD;
        @(negedge clk);
        start = 1'b0; writeHi = 1'b0;
        check("start_write_hi", 64'(hi), 64'hDEAD);
        check("start_write_busy", 64'(busy), 64'd1);
        waitDone(lat, busyCycles);
        check("start_write_latency", 64'(lat), 64'd33);
        check("start_write_res_hi", 64'(hi), 64'd0);
        check("start_write_res_lo", 64'(lo), 64'd25);

        // Asynchronous reset in the middle of an operation
        pulseStart(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        repeat (10) @(negedge clk);
        check("midop_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_hi", 64'(hi), 64'd0);
        check("async_rst_lo", 64'(lo), 64'd0);
        check("async_rst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        runOp(OP_MULTU, 32'd6, 32'd7, "after_rst", 32'd0, 32'd42, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
